ccff_loader: RTL and testbench



---
 rtl/ccff_pkg.sv | 19 +
 rtl/ccff_readback_packer.sv | 49 ++++
 rtl/ccff_loader.sv | 119 +++++++++++
 tb/tb_ccff_loader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// Shared state encoding, widths and byte-sizing helper for the ccff_loader configuration-chain driver.
package ccff_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_IDX_W = $clog2(BYTE_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    // Bits to serialize from the next byte: a full byte, or the chain's remaining tail.
    function automatic logic [BIT_IDX_W-1:0] min_bits(input int remaining);
        return (remaining >= BYTE_W) ? BIT_IDX_W'(BYTE_W) : BIT_IDX_W'(remaining);
    endfunction

endpackage

// File: rtl/ccff_readback_packer.sv
// Packs the bits falling out of ccff_tail into bytes, MSB first, zero-padding the final partial byte.
module ccff_readback_packer
    import ccff_pkg::*;
(
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              shift,
    input  logic              last,
    input  logic              tail,
    output logic [BYTE_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              rb_overflow
);

    logic [BYTE_W-1:0]    cap;
    logic [BIT_IDX_W-1:0] cnt;
    logic [BYTE_W-1:0]    cap_next;
    logic [BIT_IDX_W-1:0] cnt_next;

    assign cap_next = {cap[BYTE_W-2:0], tail};
    assign cnt_next = cnt + BIT_IDX_W'(1);

    // NOTE: the capture register is reset as well, so a reset mid-byte never leaks stale bits into rb_data.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            cap      <= '0;
            cnt      <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (shift) begin
                if (cnt_next == BIT_IDX_W'(BYTE_W) || last) begin
                    rb_data  <= cap_next << (BIT_IDX_W'(BYTE_W) - cnt_next);
                    rb_valid <= 1'b1;
                    cap      <= '0;
                    cnt      <= '0;
                end else begin
                    cap <= cap_next;
                    cnt <= cnt_next;
                end
            end
        end
    end

    // rb_valid is a one-cycle pulse with no ready, so an unacknowledged byte can never be overrun.
    assign rb_overflow = 1'b0;

endmodule

// File: rtl/ccff_loader.sv
// Byte-fed serializer driving ccff_head/ccff_shift of a CHAIN_LEN-bit configuration chain.
// Optional readback of ccff_tail into bytes is enabled by defining CCFF_READBACK_EN.
module ccff_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 31,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [BYTE_W-1:0] byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              ccff_head,
    output logic              ccff_shift,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done
`ifdef CCFF_READBACK_EN
    ,
    output logic [BYTE_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              rb_overflow
`endif
);

    state_t               state;
    logic [BYTE_W-1:0]    shreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic [BIT_IDX_W-1:0] bits_in_byte;
    logic                 byte_end;
    logic                 chain_end;

    assign byte_end  = (bits_in_byte == BIT_IDX_W'(1));
    assign chain_end = (bit_cnt == CNT_W'(CHAIN_LEN - 1));

    // NOTE: every register here is assigned with <= so all branches see the pre-edge values.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            bits_in_byte <= '0;
            byte_ready   <= 1'b0;
            ccff_head    <= 1'b0;
            ccff_shift   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        bit_cnt    <= '0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        byte_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (byte_valid && byte_ready) begin
                        state        <= SHIFT;
                        shreg        <= byte_data;
                        ccff_head    <= byte_data[BYTE_W-1];
                        ccff_shift   <= 1'b1;
                        byte_ready   <= 1'b0;
                        bits_in_byte <= min_bits(CHAIN_LEN - int'(bit_cnt));
                    end
                end
                SHIFT: begin
                    shreg        <= shreg << 1;
                    bit_cnt      <= bit_cnt + CNT_W'(1);
                    bits_in_byte <= bits_in_byte - BIT_IDX_W'(1);
                    if (byte_end) begin
                        ccff_shift <= 1'b0;
                        ccff_head  <= 1'b0;
                        if (chain_end) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state      <= LOAD;
                            byte_ready <= 1'b1;
                        end
                    end else begin
                        ccff_head <= shreg[BYTE_W-2];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assert property (@(posedge prog_clk) disable iff (prog_reset) bit_cnt <= CNT_W'(CHAIN_LEN));
    assert property (@(posedge prog_clk) disable iff (prog_reset) !(ccff_shift && byte_ready));

`ifdef CCFF_READBACK_EN
    logic last_bit;

    // The final chain bit closes the readback byte even when it is only partially filled.
    assign last_bit = ccff_shift && byte_end && chain_end;

    ccff_readback_packer u_packer (
        .prog_clk    (prog_clk),
        .prog_reset  (prog_reset),
        .shift       (ccff_shift),
        .last        (last_bit),
        .tail        (ccff_tail),
        .rb_data     (rb_data),
        .rb_valid    (rb_valid),
        .rb_overflow (rb_overflow)
    );
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: default 31-bit chain plus an 8-bit instance, optional readback.
`timescale 1ns/1ps
module tb_ccff_loader;

    localparam logic [30:0] EXP31 = 31'b1010_0101_0011_1100_1111_0000_1110_011;

    logic       prog_clk   = 1'b0;
    logic       prog_reset = 1'b1;
    logic       start      = 1'b0;
    logic [7:0] byte_data  = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_ready, ccff_head, ccff_shift, ccff_tail, busy, done;

    logic       start8      = 1'b0;
    logic [7:0] byte_data8  = 8'h00;
    logic       byte_valid8 = 1'b0;
    logic       tail8       = 1'b0;
    logic       byte_ready8, ccff_head8, ccff_shift8, busy8, done8;

    logic [30:0] chain = '0;
    logic [7:0]  stim [4];
    int total = 0;
    int bad   = 0;

    always #5 prog_clk = ~prog_clk;

    // Behavioural model of the downstream chain: ccff_head enters at bit 0, ccff_tail leaves from bit 30.
    always @(posedge prog_clk) if (ccff_shift) chain <= {chain[29:0], ccff_head};
    assign ccff_tail = chain[30];

`ifdef CCFF_READBACK_EN
    logic [7:0] rb_data, rb_data8;
    logic       rb_valid, rb_overflow, rb_valid8, rb_overflow8;
    logic [7:0] rbq [$];
    always @(negedge prog_clk) if (rb_valid) rbq.push_back(rb_data);
`endif

    ccff_loader dut (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .start      (start),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .ccff_head  (ccff_head),
        .ccff_shift (ccff_shift),
        .ccff_tail  (ccff_tail),
        .busy       (busy),
        .done       (done)
`ifdef CCFF_READBACK_EN
        ,
        .rb_data     (rb_data),
        .rb_valid    (rb_valid),
        .rb_overflow (rb_overflow)
`endif
    );

    ccff_loader #(.CHAIN_LEN(8)) dut8 (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .start      (start8),
        .byte_data  (byte_data8),
        .byte_valid (byte_valid8),
        .byte_ready (byte_ready8),
        .ccff_head  (ccff_head8),
        .ccff_shift (ccff_shift8),
        .ccff_tail  (tail8),
        .busy       (busy8),
        .done       (done8)
`ifdef CCFF_READBACK_EN
        ,
        .rb_data     (rb_data8),
        .rb_valid    (rb_valid8),
        .rb_overflow (rb_overflow8)
`endif
    );

    // Drives one load of stim[] into dut and records what appears on the chain interface.
    task automatic run_load(input int gap_after, input int gap_len, input int start_at, input int reset_at,
                            output int shifts, output logic [30:0] bits, output int done_lag,
                            output int gap_seen, output int gap_bad, output int stray, output bit timed_out);
        int idx;
        int gap_left;
        int last_shift_cyc;
        bit fire;
        idx = 0; gap_left = gap_len; shifts = 0; bits = '0; done_lag = -1;
        gap_seen = 0; gap_bad = 0; stray = 0; timed_out = 1'b1; last_shift_cyc = -100;
        @(negedge prog_clk); start = 1'b1;
        @(negedge prog_clk); start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (done) begin
                done_lag  = cyc - last_shift_cyc;
                timed_out = 1'b0;
                break;
            end
            fire = 1'b0;
            if (ccff_shift) begin
                bits = {bits[29:0], ccff_head};
                shifts++;
                last_shift_cyc = cyc;
                fire = 1'b1;
            end
            if (fire && reset_at > 0 && shifts == reset_at) begin
                prog_reset = 1'b1;
                byte_valid = 1'b0;
                timed_out  = 1'b0;
                return;
            end
            start = fire && start_at > 0 && shifts == start_at;
            if (idx == gap_after && byte_ready && gap_left > 0) begin
                byte_valid = 1'b0;
                gap_left--;
                gap_seen++;
                if (ccff_shift) gap_bad++;
            end else begin
                byte_valid = (idx < 4);
                if (idx < 4) byte_data = stim[idx];
                else         byte_data = 8'h00;
                if (byte_valid && byte_ready) idx++;
            end
            @(negedge prog_clk);
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        if (!timed_out) begin
            repeat (4) begin
                @(negedge prog_clk);
                if (ccff_shift || !done || busy || byte_ready) stray++;
            end
        end
    endtask

    task automatic test_reset();
        prog_reset = 1'b1;
        repeat (3) @(negedge prog_clk);
        total++;
        if ({byte_ready, ccff_head, ccff_shift, busy, done} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 00000", {byte_ready, ccff_head, ccff_shift, busy, done});
        end
        total++;
        if ({byte_ready8, ccff_head8, ccff_shift8, busy8, done8} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs8: got %b want 00000", {byte_ready8, ccff_head8, ccff_shift8, busy8, done8});
        end
        prog_reset = 1'b0;
        @(negedge prog_clk);
        total++;
        if ({busy, done, byte_ready} !== 3'b000) begin
            bad++;
            $display("FAIL idle_without_start: got %b want 000", {busy, done, byte_ready});
        end
    endtask

    task automatic test_basic();
        int shifts, done_lag, gap_seen, gap_bad, stray;
        logic [30:0] bits;
        bit to;
        stim = '{8'hA5, 8'h3C, 8'hF0, 8'hE6};
        run_load(-1, 0, 0, 0, shifts, bits, done_lag, gap_seen, gap_bad, stray, to);
        total++;
        if (to !== 1'b0) begin bad++; $display("FAIL basic_timeout: got %b want 0", to); end
        total++;
        if (shifts != 31) begin bad++; $display("FAIL basic_shift_count: got %0d want 31", shifts); end
        total++;
        if (bits !== EXP31) begin bad++; $display("FAIL basic_bits: got %b want %b", bits, EXP31); end
        total++;
        if (done_lag != 1) begin bad++; $display("FAIL basic_done_lag: got %0d want 1", done_lag); end
        total++;
        if (stray != 0) begin bad++; $display("FAIL basic_after_done: got %0d want 0", stray); end
    endtask

    task automatic test_stall();
        int shifts, done_lag, gap_seen, gap_bad, stray;
        logic [30:0] bits;
        bit to;
        stim = '{8'hA5, 8'h3C, 8'hF0, 8'hE6};
        run_load(2, 5, 0, 0, shifts, bits, done_lag, gap_seen, gap_bad, stray, to);
        total++;
        if (gap_seen != 5 || gap_bad != 0) begin
            bad++;
            $display("FAIL stall_gap: got seen=%0d shifting=%0d want seen=5 shifting=0", gap_seen, gap_bad);
        end
        total++;
        if (shifts != 31) begin bad++; $display("FAIL stall_shift_count: got %0d want 31", shifts); end
        total++;
        if (bits !== EXP31) begin bad++; $display("FAIL stall_bits: got %b want %b", bits, EXP31); end
        total++;
        if (done_lag != 1 || stray != 0) begin
            bad++;
            $display("FAIL stall_done: got lag=%0d stray=%0d want lag=1 stray=0", done_lag, stray);
        end
    endtask

    task automatic test_start_ignored();
        int shifts, done_lag, gap_seen, gap_bad, stray;
        logic [30:0] bits;
        bit to;
        stim = '{8'hA5, 8'h3C, 8'hF0, 8'hE6};
        run_load(-1, 0, 3, 0, shifts, bits, done_lag, gap_seen, gap_bad, stray, to);
        total++;
        if (shifts != 31) begin bad++; $display("FAIL restart_shift_count: got %0d want 31", shifts); end
        total++;
        if (bits !== EXP31) begin bad++; $display("FAIL restart_bits: got %b want %b", bits, EXP31); end
        total++;
        if (done_lag != 1 || stray != 0) begin
            bad++;
            $display("FAIL restart_done: got lag=%0d stray=%0d want lag=1 stray=0", done_lag, stray);
        end
    endtask

    task automatic test_mid_reset();
        int shifts, done_lag, gap_seen, gap_bad, stray;
        logic [30:0] bits;
        bit to;
        stim = '{8'hA5, 8'h3C, 8'hF0, 8'hE6};
        run_load(-1, 0, 0, 12, shifts, bits, done_lag, gap_seen, gap_bad, stray, to);
        @(negedge prog_clk);
        total++;
        if ({busy, done, ccff_shift, byte_ready} !== 4'b0000) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %b want 0000", {busy, done, ccff_shift, byte_ready});
        end
        prog_reset = 1'b0;
        run_load(-1, 0, 0, 0, shifts, bits, done_lag, gap_seen, gap_bad, stray, to);
        total++;
        if (shifts != 31) begin bad++; $display("FAIL reload_shift_count: got %0d want 31", shifts); end
        total++;
        if (bits !== EXP31) begin bad++; $display("FAIL reload_bits: got %b want %b", bits, EXP31); end
    endtask

    task automatic test_chain8();
        int shifts8 = 0;
        int ready_after = 0;
        int shifts_after_done = 0;
        logic [7:0] bits8 = '0;
        bit accepted = 1'b0;
        bit seen_done = 1'b0;
        @(negedge prog_clk); start8 = 1'b1;
        @(negedge prog_clk); start8 = 1'b0;
        byte_data8  = 8'h81;
        byte_valid8 = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (accepted && byte_ready8) ready_after++;
            if (byte_ready8) accepted = 1'b1;
            if (ccff_shift8) begin
                if (seen_done) shifts_after_done++;
                else begin
                    bits8 = {bits8[6:0], ccff_head8};
                    shifts8++;
                end
            end
            if (done8) seen_done = 1'b1;
            @(negedge prog_clk);
        end
        byte_valid8 = 1'b0;
        total++;
        if (shifts8 != 8) begin bad++; $display("FAIL chain8_shift_count: got %0d want 8", shifts8); end
        total++;
        if (bits8 !== 8'h81) begin bad++; $display("FAIL chain8_bits: got %h want 81", bits8); end
        total++;
        if (done8 !== 1'b1 || busy8 !== 1'b0) begin
            bad++;
            $display("FAIL chain8_done: got done=%b busy=%b want done=1 busy=0", done8, busy8);
        end
        total++;
        if (ready_after != 0 || shifts_after_done != 0) begin
            bad++;
            $display("FAIL chain8_no_second_load: got ready=%0d shifts=%0d want 0 0", ready_after, shifts_after_done);
        end
    endtask

`ifdef CCFF_READBACK_EN
    task automatic test_readback();
        int shifts, done_lag, gap_seen, gap_bad, stray;
        logic [30:0] bits;
        bit to;
        logic [7:0] exp_rb [4];
        exp_rb = '{8'h5A, 8'hC3, 8'h0F, 8'h98};
        stim = '{8'h5A, 8'hC3, 8'h0F, 8'h99};
        run_load(-1, 0, 0, 0, shifts, bits, done_lag, gap_seen, gap_bad, stray, to);
        rbq.delete();
        stim = '{default: 8'h00};
        run_load(-1, 0, 0, 0, shifts, bits, done_lag, gap_seen, gap_bad, stray, to);
        total++;
        if (rbq.size() != 4) begin bad++; $display("FAIL readback_count: got %0d want 4", rbq.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < rbq.size()) begin
                total++;
                if (rbq[i] !== exp_rb[i]) begin
                    bad++;
                    $display("FAIL readback_byte%0d: got %h want %h", i, rbq[i], exp_rb[i]);
                end
            end
        end
        total++;
        if (rb_overflow !== 1'b0) begin bad++; $display("FAIL readback_overflow: got %b want 0", rb_overflow); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_ignored();
        test_mid_reset();
        test_chain8();
`ifdef CCFF_READBACK_EN
        test_readback();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
